// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: funct3 codes, FSM states,
// the writeback NOP, and store lane helpers.
package mem_stage_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [31:0] NOP_INST = 32'h00000033;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Size comes from funct3[1:0]; byte/half lanes are picked by the address offset.
    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   store_mask = 4'b0001 << off;
            2'b01:   store_mask = off[1] ? 4'b1100 : 4'b0011;
            default: store_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   store_wdata = {4{d[7:0]}};
            2'b01:   store_wdata = {2{d[15:0]}};
            default: store_wdata = d;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_fmt.sv
// Load data formatter: selects the addressed byte/half from the returned word
// and sign- or zero-extends it according to funct3.
module mem_load_fmt
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (offset)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            LB:      data = {{24{byte_sel[7]}}, byte_sel};
            LBU:     data = {24'h000000, byte_sel};
            LH:      data = {{16{half_sel[15]}}, half_sel};
            LHU:     data = {16'h0000, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: issues data-memory requests, formats loads,
// registers MEM/WB. Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_vld,
    input  logic [31:0] i_res,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_opsel,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic        i_mem_reg,
    input  logic [4:0]  i_rd_waddr,
    input  logic        i_rd_wen,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_nxt_pc,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_mask,
    input  logic        i_dmem_ready,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_stall,
    output logic        o_vld,
    output logic        o_rd_wen,
    output logic [4:0]  o_rd_waddr,
    output logic [31:0] o_wb_data,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_nxt_pc,
    output logic        o_bus_err,
    output logic        o_trap
);

    localparam int          CW       = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam bit          TO_EN    = (WAIT_TIMEOUT != 0);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          vld_q, vld_d, rd_wen_q, rd_wen_d, bus_err_q, bus_err_d, trap_q, trap_d;
    logic [4:0]    rd_waddr_q, rd_waddr_d;
    logic [31:0]   wb_data_q, wb_data_d, inst_q, inst_d, pc_q, pc_d, nxt_pc_q, nxt_pc_d;

    logic        memop, is_store, misalign;
    logic        req, stall, retire, wen, bus_err, trap;
    logic [31:0] wb, load_data;

    assign memop    = i_vld & (i_mem_read | i_mem_write);
    assign is_store = i_mem_write & ~i_mem_read;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = ((i_opsel[1:0] == 2'b01) && i_res[0]) ||
                      ((i_opsel[1:0] == 2'b10) && (i_res[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    mem_load_fmt u_load_fmt (
        .rdata  (i_dmem_rdata),
        .offset (i_res[1:0]),
        .funct3 (i_opsel),
        .data   (load_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req     = 1'b0;
        stall   = 1'b0;
        retire  = 1'b0;
        wen     = i_rd_wen;
        wb      = i_res;
        bus_err = 1'b0;
        trap    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (memop) begin
                    if (misalign) begin
                        retire = 1'b1;
                        trap   = 1'b1;
                        wen    = 1'b0;
                    end else begin
                        req = 1'b1;
                        if (i_dmem_ready && is_store) begin
                            retire = 1'b1;
                            wen    = 1'b0;
                        end else begin
                            stall = 1'b1;
                            if (i_dmem_ready) state_d = ST_WAIT;
                        end
                    end
                end else if (i_vld) begin
                    retire = 1'b1;
                end
            end
            ST_WAIT: begin
                // A response on the expiry cycle takes priority over the timeout.
                if (i_dmem_rvalid) begin
                    retire  = 1'b1;
                    wb      = i_mem_reg ? load_data : i_res;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    retire  = 1'b1;
                    bus_err = 1'b1;
                    wen     = 1'b0;
                    wb      = '0;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        vld_d      = retire;
        rd_wen_d   = retire & wen;
        bus_err_d  = retire & bus_err;
        trap_d     = retire & trap;
        rd_waddr_d = i_rd_waddr;
        wb_data_d  = wb;
        inst_d     = retire ? i_inst : NOP_INST;
        pc_d       = i_pc;
        nxt_pc_d   = i_nxt_pc;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            vld_q      <= 1'b0;
            rd_wen_q   <= 1'b0;
            bus_err_q  <= 1'b0;
            trap_q     <= 1'b0;
            rd_waddr_q <= 5'd0;
            wb_data_q  <= 32'd0;
            inst_q     <= NOP_INST;
            pc_q       <= 32'd0;
            nxt_pc_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vld_q      <= vld_d;
            rd_wen_q   <= rd_wen_d;
            bus_err_q  <= bus_err_d;
            trap_q     <= trap_d;
            rd_waddr_q <= rd_waddr_d;
            wb_data_q  <= wb_data_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
            nxt_pc_q   <= nxt_pc_d;
        end
    end

    assign o_dmem_req   = req & ~i_rst;
    assign o_stall      = stall & ~i_rst;
    assign o_dmem_we    = is_store;
    assign o_dmem_addr  = {i_res[31:2], 2'b00};
    assign o_dmem_wdata = store_wdata(i_opsel, i_wdata);
    assign o_dmem_mask  = store_mask(i_opsel, i_res[1:0]);

    assign o_vld      = vld_q;
    assign o_rd_wen   = rd_wen_q;
    assign o_rd_waddr = rd_waddr_q;
    assign o_wb_data  = wb_data_q;
    assign o_inst     = inst_q;
    assign o_pc       = pc_q;
    assign o_nxt_pc   = nxt_pc_q;
    assign o_bus_err  = bus_err_q;
    assign o_trap     = trap_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (WAIT_TIMEOUT=4): retirements are matched
// against an expected queue; handshake outputs are checked at each step.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst, i_vld, i_mem_read, i_mem_write, i_mem_reg, i_rd_wen;
    logic [31:0] i_res, i_wdata, i_inst, i_pc, i_nxt_pc, i_dmem_rdata;
    logic [2:0]  i_opsel;
    logic [4:0]  i_rd_waddr;
    logic        i_dmem_ready, i_dmem_rvalid;
    logic        o_dmem_req, o_dmem_we, o_stall, o_vld, o_rd_wen, o_bus_err, o_trap;
    logic [31:0] o_dmem_addr, o_dmem_wdata, o_wb_data, o_inst, o_pc, o_nxt_pc;
    logic [3:0]  o_dmem_mask;
    logic [4:0]  o_rd_waddr;

    int errors = 0;
    int checks = 0;
    // {check_data, bus_err, trap, rd_wen, rd_waddr, wb_data}
    logic [40:0] exp_q[$];
    logic [40:0] e;

    always #5 i_clk = ~i_clk;

    mem_stage #(.WAIT_TIMEOUT(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_vld(i_vld), .i_res(i_res), .i_wdata(i_wdata),
        .i_opsel(i_opsel), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_mem_reg(i_mem_reg), .i_rd_waddr(i_rd_waddr), .i_rd_wen(i_rd_wen),
        .i_inst(i_inst), .i_pc(i_pc), .i_nxt_pc(i_nxt_pc),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_wdata(o_dmem_wdata), .o_dmem_mask(o_dmem_mask),
        .i_dmem_ready(i_dmem_ready), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
        .o_stall(o_stall), .o_vld(o_vld), .o_rd_wen(o_rd_wen), .o_rd_waddr(o_rd_waddr),
        .o_wb_data(o_wb_data), .o_inst(o_inst), .o_pc(o_pc), .o_nxt_pc(o_nxt_pc),
        .o_bus_err(o_bus_err), .o_trap(o_trap)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [40:0] mk(input logic cd, input logic be, input logic tr,
                                       input logic wen, input logic [4:0] wa, input logic [31:0] d);
        return {cd, be, tr, wen, wa, d};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clr_in();
        i_vld = 0; i_res = 0; i_wdata = 0; i_opsel = 0; i_mem_read = 0; i_mem_write = 0;
        i_mem_reg = 0; i_rd_waddr = 0; i_rd_wen = 0; i_inst = 32'h13; i_pc = 0; i_nxt_pc = 0;
        i_dmem_ready = 0; i_dmem_rvalid = 0; i_dmem_rdata = 0;
    endtask

    task automatic set_in(input logic [31:0] res, input logic [31:0] wd, input logic [2:0] f3,
                          input logic rd, input logic wr, input logic mreg,
                          input logic [4:0] wa, input logic wen);
        i_vld = 1; i_res = res; i_wdata = wd; i_opsel = f3; i_mem_read = rd; i_mem_write = wr;
        i_mem_reg = mreg; i_rd_waddr = wa; i_rd_wen = wen;
    endtask

    task automatic chk_hs(input string name, input logic req, input logic stall);
        #1;
        chk({name, "_req"}, 64'(o_dmem_req), 64'(req));
        chk({name, "_stall"}, 64'(o_stall), 64'(stall));
    endtask

    // Retirement monitor: sampled on the falling edge, away from the active edge.
    always @(negedge i_clk) begin
        if (!i_rst && o_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_vld", 64'(o_vld), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("bus_err", 64'(o_bus_err), 64'(e[39]));
                chk("trap", 64'(o_trap), 64'(e[38]));
                chk("rd_wen", 64'(o_rd_wen), 64'(e[37]));
                if (e[40]) begin
                    chk("rd_waddr", 64'(o_rd_waddr), 64'(e[36:32]));
                    chk("wb_data", 64'(o_wb_data), 64'(e[31:0]));
                end
            end
        end
    end

    initial begin
        clr_in();
        i_rst = 1;
        tick(); tick();
        // Memory request presented during reset must be gated off.
        set_in(32'h100, 0, LW, 1, 0, 1, 5'd3, 1);
        i_dmem_ready = 1;
        chk_hs("rst_gate", 0, 0);
        tick();
        chk("rst_vld", 64'(o_vld), 64'(0));
        chk("rst_inst", 64'(o_inst), 64'(NOP_INST));
        chk("rst_wb", 64'(o_wb_data), 64'(0));
        chk("rst_pc", 64'(o_pc), 64'(0));
        chk("rst_trap", 64'(o_trap), 64'(0));
        i_rst = 0;
        clr_in();
        tick();

        // Non-memory entry
        set_in(32'h1234, 0, 3'b000, 0, 0, 0, 5'd5, 1);
        i_inst = 32'h00500293; i_pc = 32'h40; i_nxt_pc = 32'h44;
        chk_hs("alu", 0, 0);
        exp_q.push_back(mk(1, 0, 0, 1, 5'd5, 32'h1234));
        tick();
        chk("alu_inst", 64'(o_inst), 64'h00500293);
        chk("alu_pc", 64'(o_pc), 64'h40);
        chk("alu_nxt_pc", 64'(o_nxt_pc), 64'h44);
        clr_in();

        // LB then LBU at 0x103, data two cycles after accept
        for (int k = 0; k < 2; k++) begin
            set_in(32'h103, 0, (k == 0) ? LB : LBU, 1, 0, 1, 5'd7, 1);
            i_dmem_ready = 1;
            chk_hs("lb_issue", 1, 1);
            chk("lb_addr", 64'(o_dmem_addr), 64'h100);
            chk("lb_we", 64'(o_dmem_we), 64'(0));
            exp_q.push_back(mk(1, 0, 0, 1, 5'd7, (k == 0) ? 32'hFFFFFF80 : 32'h00000080));
            tick();
            i_dmem_ready = 0;
            chk_hs("lb_wait", 0, 1);
            tick();
            i_dmem_rvalid = 1; i_dmem_rdata = 32'h80FF0000;
            chk_hs("lb_resp", 0, 0);
            tick();
            clr_in();
        end

        // SH at 0x202 with ready held low three cycles
        set_in(32'h202, 32'h0000ABCD, SH, 0, 1, 0, 5'd4, 1);
        for (int k = 0; k < 3; k++) begin
            chk_hs("sh_hold", 1, 1);
            chk("sh_mask", 64'(o_dmem_mask), 64'(4'b1100));
            chk("sh_wdata", 64'(o_dmem_wdata), 64'hABCDABCD);
            tick();
        end
        i_dmem_ready = 1;
        chk_hs("sh_accept", 1, 0);
        chk("sh_we", 64'(o_dmem_we), 64'(1));
        exp_q.push_back(mk(0, 0, 0, 0, 5'd4, 32'h0));
        tick();
        clr_in();

        // SB at offset 2, accepted immediately
        set_in(32'h6, 32'h1234565A, SB, 0, 1, 0, 5'd2, 0);
        i_dmem_ready = 1;
        chk_hs("sb", 1, 0);
        chk("sb_mask", 64'(o_dmem_mask), 64'(4'b0100));
        chk("sb_wdata", 64'(o_dmem_wdata), 64'h5A5A5A5A);
        exp_q.push_back(mk(0, 0, 0, 0, 5'd2, 32'h0));
        tick();
        clr_in();

        // LH on upper half, response on first WAIT cycle
        set_in(32'h12, 0, LH, 1, 0, 1, 5'd8, 1);
        i_dmem_ready = 1;
        chk_hs("lh_issue", 1, 1);
        exp_q.push_back(mk(1, 0, 0, 1, 5'd8, 32'hFFFF8001));
        tick();
        i_dmem_ready = 0; i_dmem_rvalid = 1; i_dmem_rdata = 32'h80017FFF;
        chk_hs("lh_resp", 0, 0);
        tick();
        clr_in();

        // LW with no response: bus error after 4 WAIT cycles
        set_in(32'h300, 0, LW, 1, 0, 1, 5'd10, 1);
        i_dmem_ready = 1;
        chk_hs("to_issue", 1, 1);
        tick();
        i_dmem_ready = 0;
        for (int k = 0; k < 3; k++) begin
            chk_hs("to_wait", 0, 1);
            tick();
        end
        chk_hs("to_expire", 0, 0);
        exp_q.push_back(mk(1, 1, 0, 0, 5'd10, 32'h0));
        tick();
        clr_in();

        // Reset during WAIT, then a stale response in IDLE
        set_in(32'h400, 0, LW, 1, 0, 1, 5'd11, 1);
        i_dmem_ready = 1;
        tick();
        i_dmem_ready = 0;
        tick();
        i_rst = 1;
        chk_hs("rst_wait", 0, 0);
        tick();
        chk("rst2_vld", 64'(o_vld), 64'(0));
        chk("rst2_wb", 64'(o_wb_data), 64'(0));
        chk("rst2_inst", 64'(o_inst), 64'(NOP_INST));
        i_rst = 0;
        clr_in();
        i_dmem_rvalid = 1; i_dmem_rdata = 32'hDEADBEEF;
        chk_hs("stale", 0, 0);
        tick();
        clr_in();
        set_in(32'h404, 0, LW, 1, 0, 1, 5'd9, 1);
        i_dmem_ready = 1;
        chk_hs("post_rst_issue", 1, 1);
        exp_q.push_back(mk(1, 0, 0, 1, 5'd9, 32'h11223344));
        tick();
        i_dmem_ready = 0; i_dmem_rvalid = 1; i_dmem_rdata = 32'h11223344;
        chk_hs("post_rst_resp", 0, 0);
        tick();
        clr_in();

        // Misaligned LW at 0x101
        set_in(32'h101, 0, LW, 1, 0, 1, 5'd12, 1);
`ifdef MEM_MISALIGN_TRAP_EN
        chk_hs("mis_trap", 0, 0);
        exp_q.push_back(mk(0, 0, 1, 0, 5'd12, 32'h0));
        tick();
`else
        i_dmem_ready = 1;
        chk_hs("mis_issue", 1, 1);
        chk("mis_addr", 64'(o_dmem_addr), 64'h100);
        chk("mis_mask", 64'(o_dmem_mask), 64'(4'b1111));
        exp_q.push_back(mk(1, 0, 0, 1, 5'd12, 32'hCAFEF00D));
        tick();
        i_dmem_ready = 0; i_dmem_rvalid = 1; i_dmem_rdata = 32'hCAFEF00D;
        chk_hs("mis_resp", 0, 0);
        tick();
`endif
        clr_in();

        tick(); tick(); tick();
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RV32I pipeline. It consumes the EX/MEM register outputs of the execute stage and produces the MEM/WB register for writeback.
- Issues data-memory requests over a req/ready + rvalid handshake, formats load data and generates store byte masks.
- Raises o_stall to freeze upstream stages while an access is outstanding.

Parameters:
- WAIT_TIMEOUT, 255: maximum cycles in WAIT before bus-error retire; 0 disables the timeout.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_vld  in  1  EX/MEM entry valid
- i_res  in  32  ALU result / effective address
- i_wdata  in  32  store data (rs2)
- i_opsel  in  3  funct3 (load/store size and sign)
- i_mem_read  in  1  load
- i_mem_write  in  1  store
- i_mem_reg  in  1  writeback selects memory data
- i_rd_waddr  in  5  destination register
- i_rd_wen  in  1  destination write enable
- i_inst, i_pc, i_nxt_pc  in  32 each  passthrough
- o_dmem_req  out  1  request valid
- o_dmem_we  out  1  1 = store
- o_dmem_addr  out  32  word-aligned address, {i_res[31:2],2'b00}
- o_dmem_wdata  out  32  lane-replicated store data
- o_dmem_mask  out  4  byte enables
- i_dmem_ready  in  1  request accepted this cycle
- i_dmem_rvalid  in  1  load data valid
- i_dmem_rdata  in  32  load data
- o_stall  out  1  hold upstream stages
- o_vld, o_rd_wen  out  1  MEM/WB valid, write enable
- o_rd_waddr  out  5  MEM/WB destination register
- o_wb_data  out  32  writeback value
- o_inst, o_pc, o_nxt_pc  out  32  MEM/WB passthrough
- o_bus_err  out  1  retired entry timed out
- o_trap  out  1  retired entry misaligned

Behaviour:
- Reset: i_rst is synchronous, active-high, on clock i_clk.
  - State = IDLE, timeout counter = 0.
  - MEM/WB outputs on reset: o_vld=0, o_rd_wen=0, o_rd_waddr=0, o_wb_data=0, o_inst=32'h00000033, o_pc=0, o_nxt_pc=0, o_bus_err=0, o_trap=0.
  - o_dmem_req and o_stall are gated low while i_rst=1.
  - Reset mid-access abandons the access; an rvalid arriving later in IDLE is ignored.
- States:
  - IDLE: no load outstanding.
  - WAIT: load accepted, awaiting rvalid.
- memop = i_vld & (i_mem_read | i_mem_write).
- Non-memory entry (i_vld=1, memop=0):
  - 1-cycle latency to MEM/WB, o_stall=0.
  - o_wb_data=i_res.
- IDLE with memop:
  - o_dmem_req=1, combinational from inputs.
  - Store and ready=1: store retires this edge with MEM/WB o_rd_wen=0 and o_stall=0. Store and ready=0: o_stall=1.
  - Load and ready=1: next state WAIT, o_stall=1. Load and ready=0: stay in IDLE, o_stall=1.
- WAIT:
  - o_dmem_req=0.
  - rvalid=1: retire with o_wb_data = i_mem_reg ? formatted load : i_res, o_stall=0, go to IDLE.
  - rvalid=0: o_stall=1.
- Stalled cycles write a bubble into MEM/WB (o_vld=0, o_rd_wen=0).
- Upstream holds all inputs stable while o_stall=1.
- Load format, byte offset b=i_res[1:0]:
  - LB(000)/LBU(100): byte b, sign-/zero-extended.
  - LH(001)/LHU(101): half i_res[1], sign-/zero-extended.
  - LW(010): full word.
  - Other funct3 values: full word.
- Store:
  - SB: mask=4'b0001<<b, wdata={4{byte}}.
  - SH: mask = i_res[1] ? 4'b1100 : 4'b0011, wdata={2{half}}.
  - SW: mask=4'b1111.
- Timeout (WAIT_TIMEOUT>0):
  - Counter increments each WAIT cycle without rvalid.
  - At count WAIT_TIMEOUT-1 with no rvalid: retire with o_bus_err=1, o_rd_wen=0, o_wb_data=0, then go to IDLE.
  - Counter clears on leaving WAIT.
  - rvalid on the same cycle as expiry wins: normal retire.
- i_vld=0: bubble, no request issued.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined:
  - Half access with i_res[0]=1, or word access with i_res[1:0]!=0, issues no request.
  - The entry retires in 1 cycle with o_trap=1 and o_rd_wen=0.
- Undefined:
  - o_trap is tied 0.
  - Misaligned accesses are issued with low address bits truncated per the mask rules above.

Decomposition:
- Shared package/header holds:
  - funct3 constants LB, LH, LW, LBU, LHU, SB, SH, SW.
  - state encodings ST_IDLE, ST_WAIT.
  - NOP instruction constant 32'h00000033.
- One combinational sub-module, mem_load_fmt: inputs rdata, offset[1:0], funct3; output 32-bit formatted data.

Test Plan:
1. Non-memory entry, i_res=32'h1234, i_rd_waddr=5 -> next cycle o_vld=1, o_wb_data=32'h1234, o_stall never asserted.
2. LB at addr 32'h103 with ready=1 and rdata=32'h80FF_0000 returned 2 cycles later -> o_stall high 2 cycles; retire o_wb_data=32'hFFFFFF80. Same access as LBU -> 32'h00000080.
3. SH at 32'h202, wdata=32'hABCD, ready held 0 for 3 cycles -> req with mask 4'b1100 and wdata 32'hABCDABCD; o_stall=1 for 3 cycles, retire on accept with rd_wen=0.
4. LW with WAIT_TIMEOUT=4, no rvalid -> o_bus_err=1, o_wb_data=0 after 4 WAIT cycles; return to IDLE.
5. i_rst asserted in WAIT, then a stale rvalid -> outputs at reset values, stale rvalid ignored, next LW completes normally.
6. With MEM_MISALIGN_TRAP_EN, LW at 32'h0101 -> no o_dmem_req; 1-cycle retire with o_trap=1, o_rd_wen=0.
